shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_mul_pkg.sv | 13 +
 rtl/shift_add_multiplier_if.sv | 26 ++
 rtl/shift_add_datapath.sv | 45 ++++
 rtl/shift_add_multiplier.sv | 92 +++++++++
 tb/tb_shift_add_multiplier.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package shift_add_mul_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle of the shift-and-add multiplier; the requester
// uses the master modport, the multiplier uses the slave modport.
interface shift_add_multiplier_if
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/shift_add_datapath.sv
// Conditional-add datapath: latched multiplicand plus the {upper, multiplier}
// shift register that accumulates the partial product one bit per step.
module shift_add_datapath
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   nextProduct_o
);

  logic [WIDTH-1:0] multiplicand_q;
  logic [WIDTH-1:0] upper_q;
  logic [WIDTH-1:0] multiplier_q;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // The carry-out becomes the new MSB after the right shift, so the
  // shifted {carry, upper, multiplier} is just {sum, multiplier[W-1:1]}.
  always_comb begin
    addend        = multiplier_q[0] ? multiplicand_q : '0;
    sum           = {1'b0, upper_q} + {1'b0, addend};
    nextProduct_o = {sum, multiplier_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multiplicand_q <= '0;
      upper_q        <= '0;
      multiplier_q   <= '0;
    end else if (load_i) begin
      multiplicand_q <= a_i;
      upper_q        <= '0;
      multiplier_q   <= b_i;
    end else if (step_i) begin
      {upper_q, multiplier_q} <= nextProduct_o;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: IDLE/RUN/DONE control and iteration counter
// around shift_add_datapath. Optional macro MUL_ZERO_BYPASS_EN skips RUN for zero operands.
module shift_add_multiplier
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   nextProduct;
  logic                 load;
  logic                 step;
  logic                 zeroOp;

`ifdef MUL_ZERO_BYPASS_EN
  assign zeroOp = (bus.a == '0) || (bus.b == '0);
`else
  assign zeroOp = 1'b0;
`endif

  shift_add_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load),
    .step_i        (step),
    .a_i           (bus.a),
    .b_i           (bus.b),
    .nextProduct_o (nextProduct)
  );

  // The product register captures the datapath's post-step value on the
  // final RUN edge so it is valid in the DONE cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (zeroOp) begin
            state_d   = DONE;
            product_d = '0;
          end else begin
            state_d = RUN;
            load    = 1'b1;
            count_d = CW'(WIDTH);
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        step    = 1'b1;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d   = DONE;
          product_d = nextProduct;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at WIDTH=4; zero-operand
// expectations follow MUL_ZERO_BYPASS_EN.
module tb_shift_add_multiplier;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   busyCycles;
  int   donePulses;
  int   expZeroLat;
  int   expZeroBusy;

  shift_add_multiplier_if #(.WIDTH(WIDTH)) mulIf ();

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mulIf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv);
    mulIf.start = s;
    mulIf.a     = av;
    mulIf.b     = bv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept on one edge, then scramble the operand inputs.
  task automatic startOp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    applyStimulus(1'b1, av, bv);
    tick();
    applyStimulus(1'b0, '0, '0);
  endtask

  // Bounded wait for done; lat counts edges since the accepting edge.
  task automatic waitDone(input int startLat);
    lat        = startLat;
    busyCycles = 0;
    while (mulIf.done !== 1'b1 && lat < 20) begin
      if (mulIf.busy === 1'b1) busyCycles++;
      tick();
      lat++;
    end
    checkOutput("doneSeen", mulIf.done, 1);
  endtask

  task automatic countDone(input int cycles);
    donePulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (mulIf.done === 1'b1) donePulses++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef MUL_ZERO_BYPASS_EN
    expZeroLat  = 1;
    expZeroBusy = 0;
`else
    expZeroLat  = WIDTH + 1;
    expZeroBusy = WIDTH;
`endif
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0);
    #12;
    checkOutput("rstBusy", mulIf.busy, 0);
    checkOutput("rstDone", mulIf.done, 0);
    checkOutput("rstProduct", mulIf.product, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] 15*15 with latency and busy window");
    startOp(4'd15, 4'd15);
    for (int i = 0; i < WIDTH - 1; i++) begin
      checkOutput("runBusy", mulIf.busy, 1);
      checkOutput("runProductHeld", mulIf.product, 0);
      tick();
    end
    checkOutput("lastRunBusy", mulIf.busy, 1);
    tick();
    checkOutput("done15x15", mulIf.done, 1);
    checkOutput("busyInDone", mulIf.busy, 0);
    checkOutput("product15x15", mulIf.product, 225);
    tick();
    checkOutput("donePulseEnds", mulIf.done, 0);
    checkOutput("productHoldIdle", mulIf.product, 225);

    $display("[TB] 9*6 with operands cleared in flight");
    startOp(4'd9, 4'd6);
    waitDone(1);
    checkOutput("lat9x6", lat, WIDTH + 1);
    checkOutput("product9x6", mulIf.product, 54);
    tick();

    $display("[TB] 0*7 zero operand");
    startOp(4'd0, 4'd7);
    waitDone(1);
    checkOutput("latZero", lat, expZeroLat);
    checkOutput("busyZero", busyCycles, expZeroBusy);
    checkOutput("productZero", mulIf.product, 0);
    tick();

    $display("[TB] start during RUN is ignored");
    startOp(4'd7, 4'd11);
    applyStimulus(1'b1, 4'd3, 4'd3);
    tick();
    applyStimulus(1'b0, '0, '0);
    waitDone(2);
    checkOutput("latIgnored", lat, WIDTH + 1);
    checkOutput("product7x11", mulIf.product, 77);
    countDone(8);
    checkOutput("singleDone", donePulses, 0);
    checkOutput("productHold77", mulIf.product, 77);

    $display("[TB] back-to-back start in DONE");
    startOp(4'd5, 4'd5);
    waitDone(1);
    checkOutput("product5x5", mulIf.product, 25);
    applyStimulus(1'b1, 4'd2, 4'd7);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("noIdleGap", mulIf.busy, 1);
    checkOutput("holdDuringRun", mulIf.product, 25);
    waitDone(1);
    checkOutput("latBackToBack", lat, WIDTH + 1);
    checkOutput("product2x7", mulIf.product, 14);
    tick();

    $display("[TB] reset during RUN");
    startOp(4'd12, 4'd13);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abortBusy", mulIf.busy, 0);
    checkOutput("abortDone", mulIf.done, 0);
    checkOutput("abortProduct", mulIf.product, 0);
    tick();
    rst = 1'b0;
    countDone(8);
    checkOutput("noDoneAfterAbort", donePulses, 0);
    startOp(4'd12, 4'd13);
    waitDone(1);
    checkOutput("latAfterReset", lat, WIDTH + 1);
    checkOutput("product12x13", mulIf.product, 156);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
